// File: rtl/parking_slot_allocator.sv
// Entry/exit front end for a 16-slot car park: lowest-free allocation, timed entry gate, occupancy map.
// Optional: define PARKING_FULL_REJECT_EN to add the entry_rej output pulsed on requests against a full map.
module parking_slot_allocator #(
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        entry_req,
  input  logic        exit_req,
  input  logic [3:0]  exit_slot,
  output logic        entry_ack,
  output logic [3:0]  entry_slot,
  output logic        gate_open,
  output logic [15:0] slots,
  output logic [4:0]  occupied_cnt,
  output logic        exit_err
`ifdef PARKING_FULL_REJECT_EN
  ,
  output logic        entry_rej
`endif
);

  typedef enum logic {IDLE, GATE} state_t;

  localparam logic [7:0] TIMER_INIT = 8'(GATE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  timer, timer_nxt;
  logic        ack_nxt;
  logic [3:0]  slot_nxt;
  logic        gate_nxt;
  logic        err_nxt;
  logic        rej_nxt;
  logic [15:0] exit_clr;
  logic [15:0] alloc_set;
  logic        alloc;
  logic        exit_ok;
  logic [15:0] slots_nxt;
  logic [4:0]  cnt_nxt;

  // Priority search: the last assignment wins, so scanning downward leaves the lowest free index.
  function automatic logic [3:0] lowest_free(input logic [15:0] map);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (!map[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    ack_nxt   = 1'b0;
    slot_nxt  = entry_slot;
    gate_nxt  = gate_open;
    err_nxt   = 1'b0;
    rej_nxt   = 1'b0;
    exit_clr  = 16'h0000;
    alloc_set = 16'h0000;
    alloc     = 1'b0;
    exit_ok   = 1'b0;

    if (exit_req) begin
      if (slots[exit_slot]) begin
        exit_ok  = 1'b1;
        exit_clr = 16'(1) << exit_slot;
      end else begin
        err_nxt = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (entry_req && slots != 16'hFFFF) begin
          alloc     = 1'b1;
          slot_nxt  = lowest_free(slots);
          alloc_set = 16'(1) << slot_nxt;
          ack_nxt   = 1'b1;
          gate_nxt  = 1'b1;
          timer_nxt = TIMER_INIT;
          state_nxt = GATE;
        end else if (entry_req) begin
          rej_nxt = 1'b1;
        end
      end
      GATE: begin
        if (timer == 8'd0) begin
          gate_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Exit clears use pre-edge slots, so a slot freed this cycle is never handed out this cycle.
    slots_nxt = (slots & ~exit_clr) | alloc_set;
    cnt_nxt   = occupied_cnt + {4'd0, alloc} - {4'd0, exit_ok};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= 8'd0;
      entry_ack    <= 1'b0;
      entry_slot   <= 4'd0;
      gate_open    <= 1'b0;
      slots        <= 16'h0000;
      occupied_cnt <= 5'd0;
      exit_err     <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      entry_ack    <= ack_nxt;
      entry_slot   <= slot_nxt;
      gate_open    <= gate_nxt;
      slots        <= slots_nxt;
      occupied_cnt <= cnt_nxt;
      exit_err     <= err_nxt;
    end
  end

`ifdef PARKING_FULL_REJECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) entry_rej <= 1'b0;
    else     entry_rej <= rej_nxt;
  end
`else
  logic unused_rej;
  assign unused_rej = rej_nxt;
`endif

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Scoreboard bench for parking_slot_allocator: a behavioural model queues expected outputs per edge.
module tb_parking_slot_allocator;
  localparam int GATE_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        entry_req = 1'b0;
  logic        exit_req = 1'b0;
  logic [3:0]  exit_slot = 4'd0;
  logic        entry_ack;
  logic [3:0]  entry_slot;
  logic        gate_open;
  logic [15:0] slots;
  logic [4:0]  occupied_cnt;
  logic        exit_err;
`ifdef PARKING_FULL_REJECT_EN
  logic        entry_rej;
`endif

  parking_slot_allocator #(.GATE_CYCLES(GATE_CYCLES)) dut (
    .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req), .exit_slot(exit_slot),
    .entry_ack(entry_ack), .entry_slot(entry_slot), .gate_open(gate_open), .slots(slots),
    .occupied_cnt(occupied_cnt), .exit_err(exit_err)
`ifdef PARKING_FULL_REJECT_EN
    , .entry_rej(entry_rej)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [3:0]  slot;
    logic        gate;
    logic [15:0] map;
    logic [4:0]  cnt;
    logic        err;
    logic        rej;
  } exp_t;

  exp_t sb_q[$];
  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  logic        m_gate_st;
  int          m_timer;
  logic [15:0] m_slots;
  logic [3:0]  m_slot;
  logic        m_gate;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    m_gate_st = 1'b0;
    m_timer   = 0;
    m_slots   = 16'h0000;
    m_slot    = 4'd0;
    m_gate    = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_edge();
    exp_t e;
    logic [15:0] ns;
    int pick;
    ns = m_slots;
    e.err = 1'b0;
    e.ack = 1'b0;
    e.rej = 1'b0;
    e.slot = m_slot;
    e.gate = m_gate;
    if (exit_req) begin
      if (m_slots[exit_slot]) ns[exit_slot] = 1'b0;
      else e.err = 1'b1;
    end
    if (!m_gate_st) begin
      if (entry_req && m_slots != 16'hFFFF) begin
        pick = -1;
        for (int i = 0; i < 16; i++) if (pick < 0 && !m_slots[i]) pick = i;
        ns[pick] = 1'b1;
        e.ack = 1'b1;
        e.slot = 4'(pick);
        e.gate = 1'b1;
        m_timer = GATE_CYCLES - 1;
        m_gate_st = 1'b1;
      end else if (entry_req) begin
        e.rej = 1'b1;
      end
    end else if (m_timer == 0) begin
      e.gate = 1'b0;
      m_gate_st = 1'b0;
    end else begin
      m_timer--;
    end
    m_slots = ns;
    e.map = ns;
    e.cnt = 5'($countones(ns));
    m_gate = e.gate;
    m_slot = e.slot;
    sb_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk("entry_ack", entry_ack, e.ack);
      chk("entry_slot", entry_slot, e.slot);
      chk("gate_open", gate_open, e.gate);
      chk("slots", slots, e.map);
      chk("occupied_cnt", occupied_cnt, e.cnt);
      chk("exit_err", exit_err, e.err);
`ifdef PARKING_FULL_REJECT_EN
      chk("entry_rej", entry_rej, e.rej);
`endif
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      entry_req = 1'($urandom);
      exit_req  = 1'($urandom);
      exit_slot = 4'($urandom);
      @(posedge clk);
      #1;
      chk("rst_ack", entry_ack, 0);
      chk("rst_gate", gate_open, 0);
      chk("rst_slots", slots, 0);
      chk("rst_cnt", occupied_cnt, 0);
      chk("rst_err", exit_err, 0);
      chk("rst_slot", entry_slot, 0);
`ifdef PARKING_FULL_REJECT_EN
      chk("rst_rej", entry_rej, 0);
`endif
    end
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_slot = 4'd0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_ack();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (entry_ack) found = 1'b1;
    end
    if (!found) chk("ack_timeout", 0, 1);
  endtask

  task automatic go_idle();
    entry_req = 1'b0;
    exit_req  = 1'b0;
    repeat (GATE_CYCLES + 1) step();
  endtask

  task automatic alloc_n(input int n);
    entry_req = 1'b1;
    for (int i = 0; i < n; i++) wait_ack();
    go_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int g;
    int acks;
    int rejs;
    bit full;

    model_reset();
    do_reset();

    // First allocation and gate timing
    entry_req = 1'b1;
    wait_ack();
    chk("first_slot", entry_slot, 0);
    chk("first_map", slots, 16'h0001);
    chk("first_cnt", occupied_cnt, 1);
    n = 0;
    g = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (entry_ack) break;
      g += int'(gate_open);
    end
    chk("ack_spacing", n, GATE_CYCLES + 1);
    chk("gate_len", g, GATE_CYCLES);
    chk("second_slot", entry_slot, 1);

    // Fill to full
    full = 1'b0;
    for (int i = 0; i < 200 && !full; i++) begin
      step();
      if (slots == 16'hFFFF) full = 1'b1;
    end
    chk("full_map", slots, 16'hFFFF);
    chk("full_cnt", occupied_cnt, 16);
    acks = 0;
    rejs = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      acks += int'(entry_ack);
`ifdef PARKING_FULL_REJECT_EN
      rejs += int'(entry_rej);
`endif
    end
    chk("full_no_ack", acks, 0);
`ifdef PARKING_FULL_REJECT_EN
    chk("full_rej_cnt", rejs, 10 - GATE_CYCLES);
`endif

    // Lowest-free refill
    entry_req = 1'b0;
    exit_req = 1'b1;
    exit_slot = 4'd9;
    step();
    exit_slot = 4'd3;
    step();
    exit_req = 1'b0;
    entry_req = 1'b1;
    wait_ack();
    chk("refill_slot", entry_slot, 3);
    chk("refill_map", slots, 16'hFDFF);
    go_idle();

    // Bad exit
    do_reset();
    alloc_n(3);
    exit_req = 1'b1;
    exit_slot = 4'd1;
    step();
    chk("pre_bad_map", slots, 16'h0005);
    step();
    chk("bad_err", exit_err, 1);
    chk("bad_map", slots, 16'h0005);
    chk("bad_cnt", occupied_cnt, 2);
    exit_req = 1'b0;
    step();
    chk("bad_err_pulse", exit_err, 0);

    // Simultaneous allocation and exit
    exit_req = 1'b1;
    exit_slot = 4'd2;
    step();
    exit_req = 1'b0;
    alloc_n(1);
    chk("sim_pre_map", slots, 16'h0003);
    entry_req = 1'b1;
    exit_req = 1'b1;
    exit_slot = 4'd0;
    step();
    chk("sim_ack", entry_ack, 1);
    chk("sim_slot", entry_slot, 2);
    chk("sim_map", slots, 16'h0006);
    chk("sim_cnt", occupied_cnt, 2);
    go_idle();
    entry_req = 1'b1;
    exit_req = 1'b1;
    exit_slot = 4'd0;
    step();
    chk("same_err", exit_err, 1);
    chk("same_slot", entry_slot, 0);
    chk("same_map", slots, 16'h0007);
    go_idle();

    // Mid-gate reset
    entry_req = 1'b1;
    wait_ack();
    step();
    chk("mid_gate_before", gate_open, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_gate", gate_open, 0);
    chk("mid_rst_map", slots, 16'h0000);
    chk("mid_rst_cnt", occupied_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    wait_ack();
    chk("post_rst_slot", entry_slot, 0);
    chk("post_rst_map", slots, 16'h0001);
    go_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/parking_slot_allocator.md
Name: parking_slot_allocator

Overview:
- Sequential front end that owns the 16-slot occupancy map consumed by the parking status stage.
- Accepts car-entry requests and allocates the lowest-numbered free slot.
- Drives an entry gate for a fixed number of cycles after each allocation.
- Accepts car-exit releases by slot index and keeps a running occupancy count.

Parameters:
- GATE_CYCLES, 4, number of cycles gate_open stays high per admitted car. Legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- entry_req  input  1  level; car waiting at entry gate
- exit_req  input  1  one-cycle strobe; car leaving slot exit_slot
- exit_slot  input  4  index of slot being vacated; valid only with exit_req
- entry_ack  output  1  one-cycle pulse; a slot was allocated
- entry_slot  output  4  slot allocated; updated with entry_ack, held until the next allocation
- gate_open  output  1  entry gate open
- slots  output  16  occupancy map; bit i = 1 means slot i is occupied. Feeds the status stage.
- occupied_cnt  output  5  number of occupied slots, 0..16
- exit_err  output  1  one-cycle pulse; exit_req was for a slot that is already free

Behaviour:
- Reset (async, immediate): slots=0, occupied_cnt=0, entry_ack=0, entry_slot=0, gate_open=0, exit_err=0, timer=0, state=IDLE. Reset mid-gate drops gate_open at once and discards any allocation in progress.
- All outputs are registered. Decisions in a cycle use the current (pre-edge) register values of slots.
- FSM states: IDLE, GATE.
- IDLE, entry_req=1 and slots!=16'hFFFF:
  - at the edge: state<=GATE, entry_ack<=1, gate_open<=1
  - entry_slot<=index of the lowest 0 bit in slots; that bit is set
  - timer<=GATE_CYCLES-1
- IDLE, entry_req=0 or slots full: no allocation and no ack; stay IDLE. The request is re-evaluated every cycle while it is held.
- GATE:
  - entry_ack<=0
  - timer==0: gate_open<=0 and state<=IDLE
  - otherwise: timer<=timer-1
  - entry_req is ignored while in GATE.
- Timing:
  - gate_open is high for exactly GATE_CYCLES cycles, starting in the cycle entry_ack is high.
  - The minimum spacing between two entry_ack pulses is GATE_CYCLES+1 cycles.
- Exit, processed in either state, every cycle:
  - exit_req=1 and slots[exit_slot]=1: clear the bit and decrement occupied_cnt; exit_err<=0.
  - exit_req=1 and slots[exit_slot]=0: exit_err<=1 for one cycle; no state change.
  - exit_req=0: exit_err<=0.
- Simultaneous allocation and valid exit in the same cycle:
  - both take effect; occupied_cnt is net unchanged.
  - The slot freed that cycle is not eligible for this allocation, because the search uses pre-edge slots.
- Exit for the slot being allocated in the same cycle: that slot is free pre-edge, so exit_err pulses and the allocation proceeds.
- Full map plus valid exit in the same cycle: no allocation that cycle. Allocation becomes possible on the next cycle if entry_req is still high.
- Invariant: occupied_cnt == popcount(slots) at every cycle. occupied_cnt never wraps: no increment past 16, no decrement below 0.

Optional Feature:
- Macro: PARKING_FULL_REJECT_EN.
- Defined:
  - extra output port entry_rej, 1 bit, reset 0.
  - entry_rej pulses for one cycle at the edge following any IDLE cycle with entry_req=1 and slots==16'hFFFF.
  - While the map stays full and the request is held, it pulses every cycle.
- Not defined: the port is absent, and a full map silently ignores entry_req.

Test Plan:
- Reset check: assert rst with random input activity -> all outputs 0. Deassert, then hold entry_req=1 (GATE_CYCLES=4) -> entry_ack pulses with entry_slot=0, slots=16'h0001, occupied_cnt=1, gate_open high for 4 cycles. The next ack arrives 5 cycles later with entry_slot=1.
- Fill to full: hold entry_req until 16 acks -> slots=16'hFFFF, occupied_cnt=16. No further ack while full. With PARKING_FULL_REJECT_EN, entry_rej pulses every IDLE cycle.
- Bad exit: from slots=16'h0005, exit_req with exit_slot=1 -> exit_err pulses once, slots stays 16'h0005, occupied_cnt stays 2.
- Lowest-free refill: from 16'hFFFF, exit slot 9 then slot 3, then entry_req -> entry_slot=3, slots=16'hFDFF.
- Simultaneous events: slots=16'h0003, entry_req plus exit of slot 0 in the same IDLE cycle -> entry_slot=2, slots=16'h0006, occupied_cnt=2.
- Mid-gate reset: assert rst during the second gate cycle -> gate_open falls immediately and slots=0. After release, the first ack gives entry_slot=0.
